// File: rtl/fetch_pkg.sv
// fetch_pkg: shared instruction-bundle constants and fetch state encoding
package fetch_pkg;
    localparam logic [5:0] OP_NOP = 6'b010011;
    localparam logic [63:0] NOP_BUNDLE = {OP_NOP, 26'b0, OP_NOP, 26'b0};
    // Encoding is {infl_v, skid_v}; 2'b11 cannot occur.
    typedef enum logic [1:0] {
        F_FILL = 2'b00,
        F_FLOW = 2'b10,
        F_HOLD = 2'b01
    } fetch_state_t;
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry {pc,inst} holding register for the word in flight during a stall
//   clk, rst          clock, synchronous active-high reset
//   load, d_pc/d_inst capture a bundle (load wins over clear)
//   clear             drop the held bundle
//   valid, q_pc/q_inst held bundle
module fetch_skid (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] d_pc,
    input  logic [63:0] d_inst,
    output logic        valid,
    output logic [31:0] q_pc,
    output logic [63:0] q_inst
);
    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [63:0] inst_q, inst_d;
    always_comb begin
        valid_d = load | (valid_q & ~clear);
        pc_d    = load ? d_pc : pc_q;
        inst_d  = load ? d_inst : inst_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end
    assign valid  = valid_q;
    assign q_pc   = pc_q;
    assign q_inst = inst_q;
endmodule

// File: rtl/fetch.sv
// fetch: dual-slot front end presenting one bundle per cycle to decode from a 1-cycle BRAM
//   clk, rst                 clock, synchronous active-high reset
//   interlock                decode cannot consume this cycle
//   branch_flag, branch_pc   redirect request and target bundle address (wins over interlock)
//   imem_en, imem_addr       BRAM read port
//   imem_dout                BRAM data for the address issued last cycle
//   pc, inst                 registered bundle presented to decode
module fetch
    import fetch_pkg::*;
#(
    parameter int          ADDR_W   = 15,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              interlock,
    input  logic              branch_flag,
    input  logic [31:0]       branch_pc,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [63:0]       imem_dout,
    output logic [31:0]       pc,
    output logic [63:0]       inst
);
    logic [31:0]  req_pc_q, req_pc_d;
    logic         infl_v_q, infl_v_d;
    logic [31:0]  infl_pc_q, infl_pc_d;
    logic [31:0]  pc_q, pc_d;
    logic [63:0]  inst_q, inst_d;
    logic         skid_load, skid_clear, skid_v;
    logic [31:0]  skid_pc;
    logic [63:0]  skid_inst;
    fetch_state_t state;
    fetch_skid u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .clear  (skid_clear),
        .d_pc   (infl_pc_q),
        .d_inst (imem_dout),
        .valid  (skid_v),
        .q_pc   (skid_pc),
        .q_inst (skid_inst)
    );
    always_comb begin
        state      = fetch_state_t'({infl_v_q, skid_v});
        req_pc_d   = req_pc_q;
        infl_v_d   = 1'b0;
        infl_pc_d  = infl_pc_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        imem_en    = 1'b0;
        imem_addr  = req_pc_q[ADDR_W-1:0];
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (!rst) begin
            if (branch_flag) begin
                // The bundle fetched behind the branch is replaced by a NOP bubble.
                imem_en    = 1'b1;
                imem_addr  = branch_pc[ADDR_W-1:0];
                infl_v_d   = 1'b1;
                infl_pc_d  = branch_pc;
                req_pc_d   = branch_pc + 32'd1;
                skid_clear = 1'b1;
                pc_d       = '0;
                inst_d     = NOP_BUNDLE;
            end else if (interlock) begin
                // The word arriving now would be lost, so park it in the skid.
                skid_load = infl_v_q;
            end else begin
                pc_d       = state == F_HOLD ? skid_pc   : state == F_FLOW ? infl_pc_q : '0;
                inst_d     = state == F_HOLD ? skid_inst : state == F_FLOW ? imem_dout : NOP_BUNDLE;
                skid_clear = 1'b1;
                imem_en    = 1'b1;
                infl_v_d   = 1'b1;
                infl_pc_d  = req_pc_q;
                req_pc_d   = req_pc_q + 32'd1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            req_pc_q  <= RESET_PC;
            infl_v_q  <= 1'b0;
            infl_pc_q <= '0;
            pc_q      <= '0;
            inst_q    <= NOP_BUNDLE;
        end else begin
            assert (!(infl_v_q && skid_v)) else $error("fetch: in-flight and skid both valid");
            req_pc_q  <= req_pc_d;
            infl_v_q  <= infl_v_d;
            infl_pc_q <= infl_pc_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
        end
    end
    assign pc   = pc_q;
    assign inst = inst_q;
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: randomized scoreboard bench for fetch against a queue-based stream model
module tb_fetch;
    import fetch_pkg::*;
    logic        clk = 1'b0;
    logic        rst, interlock, branch_flag;
    logic [31:0] branch_pc;
    logic        imem_en;
    logic [14:0] imem_addr;
    logic [63:0] imem_dout;
    logic [31:0] pc;
    logic [63:0] inst;
    typedef struct {
        logic [31:0] pc;
        logic [63:0] inst;
    } out_t;
    typedef struct {
        bit          en;
        logic [14:0] addr;
    } io_t;
    out_t        out_q[$];
    io_t         io_q[$];
    logic [31:0] pend[$];
    logic [31:0] next_fetch = 32'd0;
    int          checks = 0;
    int          failures = 0;
    fetch #(.ADDR_W(15), .RESET_PC(32'd0)) dut (
        .clk         (clk),
        .rst         (rst),
        .interlock   (interlock),
        .branch_flag (branch_flag),
        .branch_pc   (branch_pc),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_dout   (imem_dout),
        .pc          (pc),
        .inst        (inst)
    );
    always #5 clk = ~clk;
    function automatic logic [63:0] mem_word(input logic [14:0] a);
        return {17'b0, a, ~{17'b0, a}};
    endfunction
    always @(posedge clk) if (imem_en) imem_dout <= mem_word(imem_addr);
    // Model: fetched-but-not-presented bundles form a stream; a consume pops
    // the oldest one (or a NOP when none) and requests the next sequential pc.
    task automatic step(input bit r, input bit il, input bit br, input logic [31:0] bpc);
        io_t  e;
        out_t o;
        logic [31:0] p;
        rst = r; interlock = il; branch_flag = br; branch_pc = bpc;
        e.en   = !r && (br || !il);
        e.addr = br ? bpc[14:0] : next_fetch[14:0];
        io_q.push_back(e);
        o = out_q.size() > 0 ? out_q[$] : '{32'd0, NOP_BUNDLE};
        if (r) begin
            pend.delete();
            next_fetch = 32'd0;
            o = '{32'd0, NOP_BUNDLE};
        end else if (br) begin
            pend.delete();
            pend.push_back(bpc);
            next_fetch = bpc + 32'd1;
            o = '{32'd0, NOP_BUNDLE};
        end else if (!il) begin
            if (pend.size() > 0) begin
                p = pend.pop_front();
                o = '{p, mem_word(p[14:0])};
            end else o = '{32'd0, NOP_BUNDLE};
            pend.push_back(next_fetch);
            next_fetch = next_fetch + 32'd1;
        end
        out_q.push_back(o);
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        io_t  e;
        out_t o;
        if (io_q.size() > 0) begin
            e = io_q.pop_front();
            checks++;
            if (imem_en !== e.en) begin
                failures++;
                $display("FAIL imem_en got=%b exp=%b t=%0t", imem_en, e.en, $time);
            end
            if (e.en) begin
                checks++;
                if (imem_addr !== e.addr) begin
                    failures++;
                    $display("FAIL imem_addr got=%h exp=%h t=%0t", imem_addr, e.addr, $time);
                end
            end
        end
        if (out_q.size() > 1) begin
            o = out_q.pop_front();
            checks++;
            if (pc !== o.pc || inst !== o.inst) begin
                failures++;
                $display("FAIL pc/inst got=%h/%h exp=%h/%h t=%0t", pc, inst, o.pc, o.inst, $time);
            end
        end
    end
    initial begin
        logic [31:0] bpc;
        rst = 1'b1; interlock = 1'b0; branch_flag = 1'b0; branch_pc = '0;
        @(posedge clk);
        #1;
        repeat (2) step(1, 0, 0, 0);
        repeat (8) step(0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        step(0, 0, 1, 32'h40);
        repeat (4) step(0, 0, 0, 0);
        repeat (2) step(0, 1, 0, 0);
        step(0, 1, 1, 32'h40);
        repeat (3) step(0, 0, 0, 0);
        step(0, 0, 1, 32'h40);
        step(0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        step(0, 0, 1, 32'h7FFF);
        repeat (4) step(0, 0, 0, 0);
        step(0, 0, 1, 32'hFFFF_FFFF);
        repeat (3) step(0, 0, 0, 0);
        repeat (2) step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        repeat (4) step(0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: bpc = $urandom;
                1: bpc = 32'h7FFF;
                2: bpc = 32'hFFFF_FFFF;
                default: bpc = $urandom_range(0, 255);
            endcase
            step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, bpc);
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
